// File: rtl/i8284_pkg.sv
// Shared definitions for the i8088 breadboard clock/ready logic.
// The state encoding and CLK_IN:CPU-clock ratio are common to the clock generator and ready controller.
package i8284_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int WS_W_DEF  = 3;
    localparam int CLK_RATIO = 3;

    // Programmed wait count, truncated to the counter width.
    function automatic logic [WS_W_DEF-1:0] ws_trunc(input int ws);
        return WS_W_DEF'(ws);
    endfunction

endpackage

// File: rtl/rdy_sync.sv
// Two-flop synchroniser for an asynchronous ready input.
// The reset is asynchronous and active-high, and it clears both flops.
module rdy_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i8284_rdy_ctrl.sv
// Wait-state and READY sequencer for the i8088. State advances only on CLK_PH edges.
// Optional watchdog: define RDY_TIMEOUT_EN to force completion after TMO CPU clocks and flag BUS_ERR.
module i8284_rdy_ctrl
    import i8284_pkg::*;
#(
    parameter int WS_W = WS_W_DEF,
    parameter int WS0  = 0,
    parameter int WS1  = 2,
    parameter int TMO  = 15
) (
    input  logic CLK_IN,
    input  logic RST,
    input  logic CLK_PH,
    input  logic BUS_START,
    input  logic SEL,
    input  logic RDY1,
    input  logic AEN1N,
    input  logic RDY2,
    input  logic AEN2N,
    output logic READY,
    output logic BUSY,
    output logic BUS_ERR
);

    localparam logic [WS_W-1:0] WS0_T = WS_W'(WS0);
    localparam logic [WS_W-1:0] WS1_T = WS_W'(WS1);

    state_t          state;
    logic [WS_W-1:0] cnt;
    logic [WS_W-1:0] ws_load;
    logic            rdy1_s;
    logic            rdy2_s;
    logic            ext_rdy;
    logic            tmo_hit;

    rdy_sync u_sync1 (
        .clk (CLK_IN),
        .rst (RST),
        .d   (RDY1),
        .q   (rdy1_s)
    );

    rdy_sync u_sync2 (
        .clk (CLK_IN),
        .rst (RST),
        .d   (RDY2),
        .q   (rdy2_s)
    );

    // With both sources disabled, only the programmed waits apply.
    assign ext_rdy = (AEN1N & AEN2N) | (rdy1_s & ~AEN1N) | (rdy2_s & ~AEN2N);

    // SEL is consumed only here, so the count register doubles as its latch.
    assign ws_load = SEL ? WS1_T : WS0_T;

`ifdef RDY_TIMEOUT_EN
    localparam int TMO_W = (TMO < 1) ? 1 : $clog2(TMO + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             bus_err_q;

    // Fires on the CPU clock whose increment would make the count reach TMO.
    assign tmo_hit = (tmo_cnt == TMO_W'(TMO - 1));
    assign BUS_ERR = bus_err_q;
`else
    assign tmo_hit = 1'b0;
    assign BUS_ERR = 1'b0;
`endif

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            READY <= 1'b1;
            BUSY  <= 1'b0;
`ifdef RDY_TIMEOUT_EN
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
`endif
        end else if (CLK_PH) begin
            case (state)
                IDLE: begin
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                    if (BUS_START) begin
                        BUSY <= 1'b1;
                        cnt  <= ws_load;
`ifdef RDY_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (ws_load == '0 && ext_rdy) begin
                            state <= DONE;
                        end else if (ws_load == '0) begin
                            state <= EXT;
                            READY <= 1'b0;
                        end else begin
                            state <= WAIT;
                            READY <= 1'b0;
                        end
                    end
                end

                WAIT: begin
                    if (tmo_hit) begin
                        state <= DONE;
                        READY <= 1'b1;
`ifdef RDY_TIMEOUT_EN
                        bus_err_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == WS_W'(1)) begin
                            state <= EXT;
                        end
`ifdef RDY_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                // A ready arriving together with watchdog expiry wins.
                EXT: begin
                    if (ext_rdy) begin
                        state <= DONE;
                        READY <= 1'b1;
                    end else if (tmo_hit) begin
                        state <= DONE;
                        READY <= 1'b1;
`ifdef RDY_TIMEOUT_EN
                        bus_err_q <= 1'b1;
`endif
                    end else begin
`ifdef RDY_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
`ifdef RDY_TIMEOUT_EN
                    bus_err_q <= 1'b0;
`endif
                end

                default: begin
                    state <= IDLE;
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i8284_rdy_ctrl.sv
// Scoreboard bench for i8284_rdy_ctrl: per-bus-cycle expectations are queued at issue and checked when BUSY falls.
module tb_i8284_rdy_ctrl;

    logic CLK_IN = 1'b0;
    logic RST = 1'b1;
    logic CLK_PH = 1'b0;
    logic BUS_START = 1'b0;
    logic SEL = 1'b0;
    logic RDY1 = 1'b0;
    logic AEN1N = 1'b1;
    logic RDY2 = 1'b0;
    logic AEN2N = 1'b1;
    logic READY;
    logic BUSY;
    logic BUS_ERR;

    typedef struct {
        int busy;
        int low;
        int err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   align_viol = 0;
    int   extra_cycles = 0;

    i8284_rdy_ctrl #(.WS_W(3), .WS0(0), .WS1(2), .TMO(15)) dut (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .CLK_PH    (CLK_PH),
        .BUS_START (BUS_START),
        .SEL       (SEL),
        .RDY1      (RDY1),
        .AEN1N     (AEN1N),
        .RDY2      (RDY2),
        .AEN2N     (AEN2N),
        .READY     (READY),
        .BUSY      (BUSY),
        .BUS_ERR   (BUS_ERR)
    );

    // CLK_IN at 3x the CPU clock; CLK_PH high for one CLK_IN out of three.
    initial begin
        int ph_cnt;
        ph_cnt = 0;
        forever begin
            #5 CLK_IN = 1'b1;
            #5 CLK_IN = 1'b0;
            ph_cnt = (ph_cnt + 1) % 3;
            CLK_PH = (ph_cnt == 0);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: measures each bus cycle in CPU clocks and checks it against the queue.
    initial begin
        logic ph_e;
        logic prev_ready;
        logic prev_b;
        logic prev_busy;
        int   bc;
        int   lc;
        int   ec;
        exp_t e;
        prev_ready = 1'b1;
        prev_b = 1'b0;
        prev_busy = 1'b0;
        bc = 0;
        lc = 0;
        ec = 0;
        forever begin
            @(posedge CLK_IN);
            ph_e = CLK_PH;
            #2;
            if (RST) begin
                prev_busy = 1'b0;
                bc = 0;
                lc = 0;
                ec = 0;
            end else begin
                if (!ph_e && (READY !== prev_ready || BUSY !== prev_b))
                    align_viol++;
                if (ph_e) begin
                    if (BUSY === 1'b1) bc++;
                    if (READY === 1'b0) lc++;
                    if (BUS_ERR === 1'b1) ec++;
                    if (prev_busy && BUSY === 1'b0) begin
                        if (sb.size() == 0) begin
                            extra_cycles++;
                        end else begin
                            e = sb.pop_front();
                            check("busy_clks", bc, e.busy);
                            check("ready_low_clks", lc, e.low);
                            check("bus_err_clks", ec, e.err);
                        end
                        bc = 0;
                        lc = 0;
                        ec = 0;
                    end
                    prev_busy = (BUSY === 1'b1);
                end
            end
            prev_ready = READY;
            prev_b = BUSY;
        end
    end

    task automatic wait_ph();
        do @(posedge CLK_IN); while (CLK_PH !== 1'b1);
    endtask

    task automatic ph_edges(input int n);
        repeat (n) wait_ph();
    endtask

    // BUS_START is held across exactly one CLK_PH edge.
    task automatic bus_start(input logic sel);
        wait_ph();
        #1;
        BUS_START = 1'b1;
        SEL = sel;
        wait_ph();
        #1;
        BUS_START = 1'b0;
    endtask

    task automatic push(input int busy, input int low, input int err);
        exp_t e;
        e.busy = busy;
        e.low = low;
        e.err = err;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            wait_ph();
            k++;
        end
        check(tag, sb.size(), 0);
        sb.delete();
        ph_edges(2);
    endtask

    task automatic set_src(input logic a1n, input logic r1, input logic a2n, input logic r2);
        AEN1N = a1n;
        RDY1 = r1;
        AEN2N = a2n;
        RDY2 = r2;
        ph_edges(2);
    endtask

    task automatic pulse_rst();
        @(posedge CLK_IN);
        #1 RST = 1'b1;
        #1;
        check("rst_async_ready", int'(READY), 1);
        check("rst_async_busy", int'(BUSY), 0);
        @(posedge CLK_IN);
        #1 RST = 1'b0;
        ph_edges(2);
    endtask

    initial begin
        repeat (4) @(posedge CLK_IN);
        #2;
        check("reset_ready", int'(READY), 1);
        check("reset_busy", int'(BUSY), 0);
        check("reset_bus_err", int'(BUS_ERR), 0);
        #1 RST = 1'b0;

        // Zero-wait cycles through each source.
        set_src(1'b0, 1'b1, 1'b1, 1'b0);
        push(1, 0, 0);
        bus_start(1'b0);
        drain("drain_zw_rdy1");

        set_src(1'b0, 1'b0, 1'b0, 1'b1);
        push(1, 0, 0);
        bus_start(1'b0);
        drain("drain_zw_rdy2");

        // Region 1: two programmed waits plus one EXT sample.
        set_src(1'b0, 1'b1, 1'b1, 1'b0);
        push(4, 3, 0);
        bus_start(1'b1);
        drain("drain_ws1");

        // RDY2 late, two synchroniser alignments.
        set_src(1'b1, 1'b0, 1'b0, 1'b0);
        push(7, 6, 0);
        bus_start(1'b0);
        ph_edges(5);
        #1 RDY2 = 1'b1;
        drain("drain_late_a");
        set_src(1'b1, 1'b0, 1'b0, 1'b0);
        push(8, 7, 0);
        bus_start(1'b0);
        ph_edges(5);
        @(posedge CLK_IN);
        @(posedge CLK_IN);
        #1 RDY2 = 1'b1;
        drain("drain_late_b");

        // Both sources disabled; second BUS_START lands in WAIT.
        set_src(1'b1, 1'b0, 1'b1, 1'b0);
        push(4, 3, 0);
        bus_start(1'b1);
        bus_start(1'b1);
        drain("drain_no_ext");

        // Reset during EXT, then a normal cycle.
        set_src(1'b0, 1'b0, 1'b1, 1'b0);
        bus_start(1'b0);
        ph_edges(2);
        pulse_rst();
        set_src(1'b0, 1'b1, 1'b1, 1'b0);
        push(4, 3, 0);
        bus_start(1'b1);
        drain("drain_after_rst");

        // External ready stuck low.
        set_src(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef RDY_TIMEOUT_EN
        push(16, 15, 1);
        bus_start(1'b0);
        drain("drain_timeout");
`else
        bus_start(1'b0);
        ph_edges(40);
        #1;
        check("stuck_ready", int'(READY), 0);
        check("stuck_bus_err", int'(BUS_ERR), 0);
        pulse_rst();
`endif

        check("ready_align_viol", align_viol, 0);
        check("unexpected_cycles", extra_cycles, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
